vco_adc_ctrl: RTL and testbench

Conversion sequencer for the VCO-based ADC in the user project area. It powers the VCO pair up, waits a programmable settle time, then counts VCO edges over a programmable window. The result is the difference of the positive and negative VCO counts. Results go into a small result FIFO, and firmware reads them through a ready/valid port bridged from Wishbone.

---
 rtl/vco_adc_pkg.sv | 34 +++
 rtl/vco_adc_result_fifo.sv | 71 +++++++
 rtl/vco_adc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_vco_adc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_adc_pkg.sv
// -----------------------------------------------------------------------------
// vco_adc_pkg
// Shared definitions for the VCO-based ADC conversion sequencer:
//   - state_t        : sequencer FSM states
//   - DEF_CNT_W      : default width of the Gray-coded VCO edge counters
//   - DEF_WIN_W      : default width of the window-length configuration
//   - DEF_FIFO_DEPTH : default result FIFO depth (power of 2, >= 2)
//   - gray2bin       : Gray-to-binary decode, up to 32 bits wide
// -----------------------------------------------------------------------------
package vco_adc_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_W      = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WINDOW,
        CAPTURE
    } state_t;

    // Works on a zero-extended 32-bit value: leading zeros decode to zeros,
    // so callers can truncate the result back to their own counter width.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/vco_adc_result_fifo.sv
// -----------------------------------------------------------------------------
// vco_adc_result_fifo
// Show-ahead result FIFO. rd_data always reflects the head entry while
// rd_valid is high, and reads as zero while the FIFO is empty.
// Ports:
//   clock, resetb       : system clock, asynchronous active-low reset
//   push, push_data     : write request and data
//   rd_ready            : consumer accepts the head (pop when rd_valid)
//   rd_valid, rd_data   : head valid flag and head data
//   drop                : one-cycle pulse, a push was lost because the FIFO was full
// -----------------------------------------------------------------------------
module vco_adc_result_fifo
    import vco_adc_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && rd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; contents are only ever observed through valid pointers.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers advance independently on accepted push/pop.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/vco_adc_ctrl.sv
// -----------------------------------------------------------------------------
// vco_adc_ctrl
// Conversion sequencer for the VCO ADC: enables the VCO pair, waits a settle
// time, counts VCO edges over a window and pushes (d_p - d_n) into a FIFO.
// Ports:
//   clock, resetb          : system clock, asynchronous active-low reset
//   cfg_window, cfg_settle : window / settle lengths in cycles (0 acts as 1)
//   cfg_cont               : back-to-back continuous windows
//   start, stop            : begin a conversion / abort (stop wins)
//   vco_en                 : analog enable for both VCOs
//   vco_cnt_p, vco_cnt_n   : asynchronous Gray-coded VCO edge counts
//   rd_valid, rd_data      : FIFO head (signed CNT_W+1 result)
//   rd_ready               : consumer accepts the head
//   busy                   : sequencer not idle
//   overflow               : sticky, a result was dropped (cleared on start)
// -----------------------------------------------------------------------------
module vco_adc_ctrl
    import vco_adc_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [7:0]       cfg_settle,
    input  logic             cfg_cont,
    input  logic             start,
    input  logic             stop,
    output logic             vco_en,
    input  logic [CNT_W-1:0] vco_cnt_p,
    input  logic [CNT_W-1:0] vco_cnt_n,
    output logic             rd_valid,
    output logic [CNT_W:0]   rd_data,
    input  logic             rd_ready,
    output logic             busy,
    output logic             overflow
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] sync_p1, sync_p2, sync_n1, sync_n2;
    logic [CNT_W-1:0] cnt_p_b, cnt_n_b;
    logic [CNT_W-1:0] base_p, base_n, end_p, end_n;
    logic [CNT_W-1:0] d_p, d_n;
    logic [CNT_W:0]   result;
    logic [7:0]       settle_cnt;
    logic [7:0]       settle_init;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_init;
    logic             load_settle, load_win, latch_base, latch_end, rebase;
    logic             push, clr_ovf, drop;

    // Two-flop synchronisers; Gray coding keeps each sampled value within one
    // count of the true value even when the counter is mid-transition.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            sync_n1 <= '0;
            sync_n2 <= '0;
        end else begin
            sync_p1 <= vco_cnt_p;
            sync_p2 <= sync_p1;
            sync_n1 <= vco_cnt_n;
            sync_n2 <= sync_n1;
        end
    end

    assign cnt_p_b = CNT_W'(gray2bin(32'(sync_p2)));
    assign cnt_n_b = CNT_W'(gray2bin(32'(sync_n2)));

    assign settle_init = (cfg_settle == '0) ? 8'd1 : cfg_settle;
    assign win_init    = (cfg_window == '0) ? WIN_W'(1) : cfg_window;

    // Modular deltas tolerate counter wrap; zero-extending before the final
    // subtraction gives a correctly signed CNT_W+1 result.
    assign d_p    = end_p - base_p;
    assign d_n    = end_n - base_n;
    assign result = {1'b0, d_p} - {1'b0, d_n};

    assign vco_en = (state != IDLE);
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes. stop overrides everything in any busy
    // state, including the push and the continuous-mode reload in CAPTURE.
    always_comb begin
        state_next  = state;
        load_settle = 1'b0;
        load_win    = 1'b0;
        latch_base  = 1'b0;
        latch_end   = 1'b0;
        rebase      = 1'b0;
        push        = 1'b0;
        clr_ovf     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next  = SETTLE;
                    load_settle = 1'b1;
                    clr_ovf     = 1'b1;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (settle_cnt == 8'd1) begin
                    state_next = WINDOW;
                    latch_base = 1'b1;
                    load_win   = 1'b1;
                end
            end
            WINDOW: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (win_cnt == WIN_W'(1)) begin
                    state_next = CAPTURE;
                    latch_end  = 1'b1;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    push = 1'b1;
                    if (cfg_cont) begin
                        state_next = WINDOW;
                        rebase     = 1'b1;
                        load_win   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, base/end snapshots and the sticky overflow flag. In continuous
    // mode the previous end becomes the next base so no edges go uncounted.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            base_p     <= '0;
            base_n     <= '0;
            end_p      <= '0;
            end_n      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load_settle) begin
                settle_cnt <= settle_init;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            if (load_win) begin
                win_cnt <= win_init;
            end else if (state == WINDOW) begin
                win_cnt <= win_cnt - WIN_W'(1);
            end
            if (latch_base) begin
                base_p <= cnt_p_b;
                base_n <= cnt_n_b;
            end else if (rebase) begin
                base_p <= end_p;
                base_n <= end_n;
            end
            if (latch_end) begin
                end_p <= cnt_p_b;
                end_n <= cnt_n_b;
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    vco_adc_result_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (push),
        .push_data (result),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .drop      (drop)
    );

endmodule

// File: tb/tb_vco_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vco_adc_ctrl
// Directed bench for vco_adc_ctrl. A behavioural VCO model drives Gray-coded
// counts that advance a programmable amount per clock; expected results and
// cycle positions are hand-computed from the window/settle settings.
// -----------------------------------------------------------------------------
module tb_vco_adc_ctrl;

    logic        clock;
    logic        resetb;
    logic [15:0] cfg_window;
    logic [7:0]  cfg_settle;
    logic        cfg_cont;
    logic        start;
    logic        stop;
    logic        vco_en;
    logic [15:0] vco_cnt_p;
    logic [15:0] vco_cnt_n;
    logic        rd_valid;
    logic [16:0] rd_data;
    logic        rd_ready;
    logic        busy;
    logic        overflow;

    int          check_count = 0;
    int          error_count = 0;

    // VCO model state; p_inc/n_inc/n_half/p_offset are steered by the main sequence.
    logic [15:0] p_bin = '0;
    logic [15:0] n_bin = '0;
    logic [15:0] p_offset = '0;
    int          p_inc = 1;
    int          n_inc = 0;
    bit          n_half = 1'b0;
    bit          n_phase = 1'b0;

    vco_adc_ctrl #(
        .CNT_W      (16),
        .WIN_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .cfg_window (cfg_window),
        .cfg_settle (cfg_settle),
        .cfg_cont   (cfg_cont),
        .start      (start),
        .stop       (stop),
        .vco_en     (vco_en),
        .vco_cnt_p  (vco_cnt_p),
        .vco_cnt_n  (vco_cnt_n),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // Free-running VCO counters, updated shortly after each rising edge.
    initial begin
        vco_cnt_p = '0;
        vco_cnt_n = '0;
        forever begin
            @(posedge clock);
            #2;
            p_bin = p_bin + 16'(p_inc);
            if (!n_half || n_phase) begin
                n_bin = n_bin + 16'(n_inc);
            end
            n_phase   = !n_phase;
            vco_cnt_p = bin2gray(p_bin + p_offset);
            vco_cnt_n = bin2gray(n_bin);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then step 1 ns past the edge for sampling/driving.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetb = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
        waitCycles(1);
    endtask

    // Program the configuration and pulse start; start is sampled on "edge 0"
    // and the task returns 1 ns into cycle 1.
    task automatic applyStimulus(input logic [7:0] settle, input logic [15:0] window,
                                 input logic cont);
        cfg_settle = settle;
        cfg_window = window;
        cfg_cont   = cont;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Pop the head entry in the current cycle.
    task automatic popOne();
        rd_ready = 1'b1;
        waitCycles(1);
        rd_ready = 1'b0;
    endtask

    int drain_count;

    initial begin
        resetb     = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        rd_ready   = 1'b0;
        cfg_window = '0;
        cfg_settle = '0;
        cfg_cont   = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_vco_en", 32'(vco_en), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);

        // Basic conversion: p 1/clock, n 1 per 2 clocks, S=4, W=100 -> +50
        p_inc = 1; n_inc = 1; n_half = 1'b1;
        applyStimulus(8'd4, 16'd100, 1'b0);
        checkOutput("basic_vco_en_c1", 32'(vco_en), 32'd1);
        checkOutput("basic_busy_c1", 32'(busy), 32'd1);
        waitCycles(104);
        checkOutput("basic_valid_c105", 32'(rd_valid), 32'd0);
        checkOutput("basic_busy_c105", 32'(busy), 32'd1);
        waitCycles(1);
        checkOutput("basic_valid_c106", 32'(rd_valid), 32'd1);
        checkOutput("basic_busy_c106", 32'(busy), 32'd0);
        checkOutput("basic_result", 32'(rd_data), 32'd50);
        popOne();
        checkOutput("basic_single_result", 32'(rd_valid), 32'd0);

        // Wrap-around: p crosses 0xFFFF->0x0000 inside a 64-cycle window
        n_inc = 0; n_half = 1'b0;
        p_offset = 16'hFFF0 - p_bin;
        applyStimulus(8'd2, 16'd64, 1'b0);
        waitCycles(67);
        checkOutput("wrap_valid", 32'(rd_valid), 32'd1);
        checkOutput("wrap_result", 32'(rd_data), 32'd64);
        popOne();

        // Negative result: p +1/clock, n +3/clock, W=20 -> -40
        n_inc = 3;
        applyStimulus(8'd1, 16'd20, 1'b0);
        waitCycles(22);
        checkOutput("neg_valid", 32'(rd_valid), 32'd1);
        checkOutput("neg_result", 32'(rd_data), 32'h1FFD8);
        popOne();

        // Zero settle/window act as 1: result visible in cycle 4
        n_inc = 0;
        applyStimulus(8'd0, 16'd0, 1'b0);
        waitCycles(2);
        checkOutput("zero_valid_c3", 32'(rd_valid), 32'd0);
        checkOutput("zero_busy_c3", 32'(busy), 32'd1);
        waitCycles(1);
        checkOutput("zero_valid_c4", 32'(rd_valid), 32'd1);
        checkOutput("zero_result", 32'(rd_data), 32'd1);
        checkOutput("zero_busy_c4", 32'(busy), 32'd0);
        popOne();

        // Overflow: continuous, W=10, no reads. Pushes on edges 12,23,34,45;
        // edge 56 is dropped; edge 67 coincides with a pop.
        applyStimulus(8'd1, 16'd10, 1'b1);
        waitCycles(54);
        checkOutput("ovf_flag_c55", 32'(overflow), 32'd0);
        checkOutput("ovf_head_c55", 32'(rd_data), 32'd10);
        waitCycles(2);
        checkOutput("ovf_flag_c57", 32'(overflow), 32'd1);
        checkOutput("ovf_head_c57", 32'(rd_data), 32'd10);
        waitCycles(10);
        popOne();
        stop = 1'b1;
        waitCycles(1);
        stop = 1'b0;
        checkOutput("ovf_stop_busy", 32'(busy), 32'd0);
        drain_count = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rd_valid) begin
                drain_count++;
                checkOutput("ovf_drain_data", 32'(rd_data), 32'd11);
            end
            waitCycles(1);
        end
        rd_ready = 1'b0;
        checkOutput("ovf_occupancy", 32'(drain_count), 32'd4);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        // Stop mid-window at window cycle 30 (cycle 34), then a normal run
        applyStimulus(8'd4, 16'd100, 1'b0);
        checkOutput("stop_ovf_cleared", 32'(overflow), 32'd0);
        waitCycles(33);
        checkOutput("stop_busy_c34", 32'(busy), 32'd1);
        stop = 1'b1;
        waitCycles(1);
        stop = 1'b0;
        checkOutput("stop_vco_en_c35", 32'(vco_en), 32'd0);
        checkOutput("stop_busy_c35", 32'(busy), 32'd0);
        waitCycles(80);
        checkOutput("stop_no_push", 32'(rd_valid), 32'd0);
        applyStimulus(8'd2, 16'd10, 1'b0);
        waitCycles(13);
        checkOutput("restart_valid", 32'(rd_valid), 32'd1);
        checkOutput("restart_result", 32'(rd_data), 32'd10);
        popOne();

        // Reset during WINDOW with two results queued
        applyStimulus(8'd1, 16'd10, 1'b1);
        waitCycles(27);
        checkOutput("rstmid_pre_valid", 32'(rd_valid), 32'd1);
        checkOutput("rstmid_pre_busy", 32'(busy), 32'd1);
        resetb = 1'b0;
        #1;
        checkOutput("rstmid_vco_en", 32'(vco_en), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rstmid_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rstmid_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
        waitCycles(3);
        checkOutput("rstmid_fifo_empty", 32'(rd_valid), 32'd0);
        checkOutput("rstmid_idle", 32'(busy), 32'd0);

        // Ignored start while busy; cfg_window change applies to the next window
        applyStimulus(8'd2, 16'd20, 1'b1);
        waitCycles(9);
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        waitCycles(1);
        cfg_window = 16'd8;
        waitCycles(11);
        checkOutput("cfg_valid_c23", 32'(rd_valid), 32'd0);
        checkOutput("cfg_busy_c23", 32'(busy), 32'd1);
        waitCycles(1);
        checkOutput("cfg_valid_c24", 32'(rd_valid), 32'd1);
        checkOutput("cfg_first_result", 32'(rd_data), 32'd20);
        popOne();
        checkOutput("cfg_valid_c25", 32'(rd_valid), 32'd0);
        waitCycles(7);
        checkOutput("cfg_valid_c32", 32'(rd_valid), 32'd0);
        waitCycles(1);
        checkOutput("cfg_valid_c33", 32'(rd_valid), 32'd1);
        checkOutput("cfg_second_result", 32'(rd_data), 32'd9);
        stop = 1'b1;
        waitCycles(1);
        stop = 1'b0;
        checkOutput("cfg_stop_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
